somador_serial_n_bits: RTL and testbench

//   Bit-serial N-bit adder: latches two N-bit operands on start, resolves one bit per clock

---
 rtl/somador_pkg.sv | 41 ++++
 rtl/somador_serial_n_bits_celula.sv | 19 +
 rtl/somador_serial_n_bits.sv | 159 +++++++++++++++
 tb/tb_somador_serial_n_bits.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/somador_pkg.sv
// somador_pkg
//   Shared definitions for the bit-serial adder:
//     state_t    : FSM states (IDLE, RUN, DONE)
//     SEG_BLANK  : all segments off (active-low)
//     hex_to_seg : 4-bit value -> active-low 7-segment code {g,f,e,d,c,b,a}
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (v)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/somador_serial_n_bits_celula.sv
// celula_somador
//   Single-bit full adder, the only arithmetic cell of the serial adder.
//   Ports:
//     a, b : operand bits
//     cin  : carry in
//     s    : sum bit
//     cout : carry out (majority of a, b, cin)
module celula_somador (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/somador_serial_n_bits.sv
// somador_serial_n_bits
//   Bit-serial N-bit adder. On an accepted start the operands are latched,
//   then one bit per clock is resolved through a single full-adder cell,
//   LSB first. The committed result is held until the next operation ends
//   and is shown on active-low 7-segment digits.
//
//   Optional feature: define SERIAL_SUB_EN to add the sub input
//   (sub=1 computes A + ~B + 1; cout=1 then means "no borrow").
//
//   Ports:
//     CLOCK_50  : clock, rising edge
//     rst       : asynchronous active-high reset
//     start     : level, sampled only in IDLE
//     a, b      : N-bit operands, captured on accepted start
//     sub       : (SERIAL_SUB_EN only) subtract select, captured on start
//     sum       : committed result
//     cout      : carry out / not-borrow of committed result
//     ovf       : two's-complement overflow of committed result
//     busy      : high from the cycle after start until the commit cycle
//     done      : one-cycle pulse after the result is committed
//     hex       : digit k at [7k+6:7k], {g,f,e,d,c,b,a}, 0 = lit
//     state_dbg : current FSM state (debug observation)
//
//   Handshake: start is a level request; it is accepted on any rising edge
//   where the FSM is in IDLE. There is no back-pressure; done marks the
//   cycle in which sum/cout/ovf first show the new result.
module somador_serial_n_bits
    import somador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N-1:0]             a,
    input  logic [N-1:0]             b,
`ifdef SERIAL_SUB_EN
    input  logic                     sub,
`endif
    output logic [N-1:0]             sum,
    output logic                     cout,
    output logic                     ovf,
    output logic                     busy,
    output logic                     done,
    output logic [7*((N+3)/4)-1:0]   hex,
    output logic [1:0]               state_dbg
);

    localparam int DIGITS = (N + 3) / 4;
    localparam int CW     = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state;
    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;     // already inverted when subtracting
    logic [N-1:0]    res;
    logic            c;
    logic            c_msb;    // carry into the MSB, needed for overflow
    logic [CW-1:0]   cnt;

    logic            fa_s;
    logic            fa_co;
    logic [N-1:0]    res_next;

    logic            cin_sel;
    logic [N-1:0]    b_sel;

`ifdef SERIAL_SUB_EN
    assign cin_sel = sub;
    assign b_sel   = sub ? ~b : b;
`else
    assign cin_sel = 1'b0;
    assign b_sel   = b;
`endif

    celula_somador u_celula (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_co)
    );

    // New bit enters at the MSB so that after N shifts res holds the sum
    // in natural order; written this way so N=1 needs no special case.
    always_comb begin
        res_next        = res >> 1;
        res_next[N-1]   = fa_s;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            c     <= 1'b0;
            c_msb <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_sel;
                        c     <= cin_sel;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res  <= res_next;
                    c    <= fa_co;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        c_msb <= c;
                        state <= DONE;
                    end
                end
                DONE: begin
                    sum   <= res;
                    cout  <= c;
                    ovf   <= c_msb ^ c;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

    // Digits are decoded from the committed sum, zero-padded to whole nibbles.
    logic [4*DIGITS-1:0] sum_pad;

    always_comb begin
        sum_pad        = '0;
        sum_pad[N-1:0] = sum;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        assign hex[7*k +: 7] = hex_to_seg(sum_pad[4*k +: 4]);
    end

endmodule

// File: tb/tb_somador_serial_n_bits.sv
module tb_somador_serial_n_bits;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT N=8 ----------------
    logic        start8;
    logic [7:0]  a8, b8, sum8;
    logic        cout8, ovf8, busy8, done8;
    logic [13:0] hex8;
    logic [1:0]  st8;
    // ---------------- DUT N=1 ----------------
    logic        start1;
    logic [0:0]  a1, b1, sum1;
    logic        cout1, ovf1, busy1, done1;
    logic [6:0]  hex1;
    logic [1:0]  st1;
    // ---------------- DUT N=6 ----------------
    logic        start6;
    logic [5:0]  a6, b6, sum6;
    logic        cout6, ovf6, busy6, done6;
    logic [13:0] hex6;
    logic [1:0]  st6;
`ifdef SERIAL_SUB_EN
    logic sub8, sub1, sub6;
`endif

    somador_serial_n_bits #(.N(8)) dut8 (
        .CLOCK_50(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_SUB_EN
        .sub(sub8),
`endif
        .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8),
        .hex(hex8), .state_dbg(st8)
    );

    somador_serial_n_bits #(.N(1)) dut1 (
        .CLOCK_50(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_SUB_EN
        .sub(sub1),
`endif
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1),
        .hex(hex1), .state_dbg(st1)
    );

    somador_serial_n_bits #(.N(6)) dut6 (
        .CLOCK_50(clk), .rst(rst), .start(start6), .a(a6), .b(b6),
`ifdef SERIAL_SUB_EN
        .sub(sub6),
`endif
        .sum(sum6), .cout(cout6), .ovf(ovf6), .busy(busy6), .done(done6),
        .hex(hex6), .state_dbg(st6)
    );

    // ---------------- reference model ----------------
    localparam logic [6:0] SEG [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [13:0] HEX_ZERO2 = {7'b1000000, 7'b1000000};

    // Returns {ovf, cout, sum[7:0]} for an n-bit add (s=0) or subtract (s=1).
    function automatic logic [9:0] ref_model(input int n, input int x, input int y, input int s);
        int mask, yy, t, r, co, sx, sy, sr, ov;
        mask = (1 << n) - 1;
        yy   = (s != 0) ? (~y & mask) : (y & mask);
        t    = (x & mask) + yy + s;
        r    = t & mask;
        co   = (t >> n) & 1;
        sx   = (x >> (n - 1)) & 1;
        sy   = (yy >> (n - 1)) & 1;
        sr   = (r >> (n - 1)) & 1;
        ov   = (sx == sy && sr != sx) ? 1 : 0;
        return {ov[0], co[0], r[7:0]};
    endfunction

    function automatic logic [13:0] exp_hex2(input logic [7:0] v);
        return {SEG[v[7:4]], SEG[v[3:0]]};
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q[$];

    // ---------------- driver tasks ----------------
    // Each op task returns the number of rising edges after the capture edge
    // until done is seen (bounded).
    task automatic op8(input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        a8 = x; b8 = y; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op1(input logic [0:0] x, input logic [0:0] y, output int lat);
        @(negedge clk);
        a1 = x; b1 = y; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op6(input logic [5:0] x, input logic [5:0] y, output int lat);
        @(negedge clk);
        a6 = x; b6 = y; start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        lat = 0;
        while (done6 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start8 = 0; start1 = 0; start6 = 0;
        a8 = 0; b8 = 0; a1 = 0; b1 = 0; a6 = 0; b6 = 0;
`ifdef SERIAL_SUB_EN
        sub8 = 0; sub1 = 0; sub6 = 0;
`endif
        repeat (2) @(negedge clk);
        n_checks++; if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000)
            $display("FAIL reset_out8: got %h want 000", {sum8, cout8, ovf8, busy8, done8}); else n_pass++;
        n_checks++; if (hex8 !== HEX_ZERO2)
            $display("FAIL reset_hex8: got %h want %h", hex8, HEX_ZERO2); else n_pass++;
        n_checks++; if ({sum6, hex6} !== {6'd0, HEX_ZERO2} || hex1 !== 7'b1000000)
            $display("FAIL reset_small: sum6=%h hex6=%h hex1=%h", sum6, hex6, hex1); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        op8(8'h3C, 8'h05, lat);
        n_checks++; if (lat !== 9)
            $display("FAIL basic_latency: got %0d want 9", lat); else n_pass++;
        n_checks++; if ({sum8, cout8, ovf8} !== {8'h41, 1'b0, 1'b0})
            $display("FAIL basic_result: got %h/%b/%b want 41/0/0", sum8, cout8, ovf8); else n_pass++;
        n_checks++; if (hex8 !== {7'h19, 7'h79})
            $display("FAIL basic_hex: got %h want %h", hex8, {7'h19, 7'h79}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({done8, busy8} !== 2'b00 || sum8 !== 8'h41)
            $display("FAIL basic_pulse: done=%b busy=%b sum=%h want 0 0 41", done8, busy8, sum8); else n_pass++;
    endtask

    task automatic test_carry_ovf();
        int lat;
        op8(8'hFF, 8'h01, lat);
        n_checks++; if ({sum8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0} || lat !== 9)
            $display("FAIL carry_ff01: got %h/%b/%b lat %0d want 00/1/0 lat 9", sum8, cout8, ovf8, lat); else n_pass++;
        op8(8'h7F, 8'h01, lat);
        n_checks++; if ({sum8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1})
            $display("FAIL ovf_7f01: got %h/%b/%b want 80/0/1", sum8, cout8, ovf8); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int lat, seen;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy8 !== 1'b1)
            $display("FAIL midrun_busy: got %b want 1", busy8); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000 || hex8 !== HEX_ZERO2)
            $display("FAIL midrun_reset: got %h hex %h want 000 hex %h",
                     {sum8, cout8, ovf8, busy8, done8}, hex8, HEX_ZERO2); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0)
            $display("FAIL midrun_no_done: got %0d pulses want 0", seen); else n_pass++;
        op8(8'h01, 8'h01, lat);
        n_checks++; if (sum8 !== 8'h02 || lat !== 9)
            $display("FAIL after_reset_op: got %h lat %0d want 02 lat 9", sum8, lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        localparam int P = 10;
        logic [7:0] x, y;
        logic [9:0] e;
        logic exp_done, exp_busy;
        for (int j = 0; j <= 3 * P; j++) begin
            if (j > 0) begin
                exp_done = (j % P == 0);
                exp_busy = (j % P != 0);
                n_checks++; if (done8 !== exp_done)
                    $display("FAIL b2b_done cyc %0d: got %b want %b", j, done8, exp_done); else n_pass++;
                n_checks++; if (busy8 !== exp_busy)
                    $display("FAIL b2b_busy cyc %0d: got %b want %b", j, busy8, exp_busy); else n_pass++;
                if (exp_done && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_checks++; if ({ovf8, cout8, sum8} !== e)
                        $display("FAIL b2b_result cyc %0d: got %h want %h", j, {ovf8, cout8, sum8}, e); else n_pass++;
                end
            end
            if (j % P == 0 && j < 3 * P) begin
                x = 8'($urandom_range(0, 255));
                y = 8'($urandom_range(0, 255));
                a8 = x; b8 = y; start8 = 1'b1;
                exp_q.push_back(ref_model(8, int'(x), int'(y), 0));
            end else begin
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                if (j > 2 * P) start8 = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        n_checks++; if (exp_q.size() !== 0)
            $display("FAIL b2b_queue: %0d results left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] x, y;
        logic [9:0] e;
        for (int i = 0; i < 24; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_model(8, int'(x), int'(y), 0));
            op8(x, y, lat);
            e = exp_q.pop_front();
            n_checks++; if ({ovf8, cout8, sum8} !== e || lat !== 9)
                $display("FAIL rand_op %h+%h: got %h lat %0d want %h lat 9", x, y, {ovf8, cout8, sum8}, lat, e); else n_pass++;
            n_checks++; if (hex8 !== exp_hex2(e[7:0]))
                $display("FAIL rand_hex %h: got %h want %h", e[7:0], hex8, exp_hex2(e[7:0])); else n_pass++;
        end
    endtask

`ifdef SERIAL_SUB_EN
    task automatic test_sub();
        int lat;
        sub8 = 1'b1;
        op8(8'h05, 8'h07, lat);
        n_checks++; if ({sum8, cout8} !== {8'hFE, 1'b0})
            $display("FAIL sub_05_07: got %h/%b want fe/0", sum8, cout8); else n_pass++;
        op8(8'h07, 8'h05, lat);
        n_checks++; if ({sum8, cout8} !== {8'h02, 1'b1})
            $display("FAIL sub_07_05: got %h/%b want 02/1", sum8, cout8); else n_pass++;
        sub8 = 1'b0;
    endtask
`endif

    task automatic test_exhaustive_n1();
        int lat;
        logic [9:0] e;
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                e = ref_model(1, x, y, 0);
                op1(x[0:0], y[0:0], lat);
                n_checks++; if ({ovf1, cout1, sum1} !== {e[9], e[8], e[0]} || lat !== 2)
                    $display("FAIL n1 %0d+%0d: got %b%b%b lat %0d want %b%b%b lat 2",
                             x, y, ovf1, cout1, sum1, lat, e[9], e[8], e[0]); else n_pass++;
                n_checks++; if (hex1 !== SEG[{3'b000, e[0]}])
                    $display("FAIL n1_hex %0d+%0d: got %h want %h", x, y, hex1, SEG[{3'b000, e[0]}]); else n_pass++;
            end
        end
    endtask

    task automatic test_exhaustive_n6();
        int lat, bad_top;
        logic [9:0] e;
        logic [13:0] eh;
        bad_top = 0;
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                e  = ref_model(6, x, y, 0);
                eh = exp_hex2({2'b00, e[5:0]});
                op6(x[5:0], y[5:0], lat);
                n_checks++; if ({ovf6, cout6, sum6} !== {e[9], e[8], e[5:0]} || lat !== 7 || hex6 !== eh)
                    $display("FAIL n6 %0d+%0d: got %b%b%h hex %h lat %0d want %b%b%h hex %h lat 7",
                             x, y, ovf6, cout6, sum6, hex6, lat, e[9], e[8], e[5:0], eh); else n_pass++;
                if (hex6[13:7] !== SEG[0] && hex6[13:7] !== SEG[1] &&
                    hex6[13:7] !== SEG[2] && hex6[13:7] !== SEG[3]) bad_top++;
            end
        end
        n_checks++; if (bad_top !== 0)
            $display("FAIL n6_top_digit: %0d results outside 0-3 want 0", bad_top); else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_carry_ovf();
        test_reset_midrun();
        test_back_to_back();
        test_random();
`ifdef SERIAL_SUB_EN
        test_sub();
`endif
        test_exhaustive_n1();
        test_exhaustive_n6();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
